wb_select_pipe: RTL

//  Parametrised successor to the 2:1 register-file write-data select. Picks one of NSRC

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_skid_buffer.sv | 110 +++++++++++
 rtl/wb_select_pipe.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and helpers for the writeback select pipeline.
//   wb_state_t  : occupancy of the 2-entry skid buffer (EMPTY / ONE / FULL)
//   wb_entry_t  : entry layout {data, rd, we} at the default widths
//                 (32-bit data, 5-bit register address)
//   sel_w()     : width of a source-select index for a given source count
// No ports.
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_ONE   = 2'd1,
        WB_FULL  = 2'd2
    } wb_state_t;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // Reference layout of one held entry. The top declares the same
    // {data, rd, we} ordering with its own parameter widths.
    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] rd;
        logic                 we;
    } wb_entry_t;

    // Select index width; never narrower than one bit.
    function automatic int sel_w(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// -----------------------------------------------------------------------------
// wb_skid_buffer
// Generic 2-entry valid/ready buffer over a packed entry of W bits.
// Strict FIFO order. Occupancy is tracked by a small state machine;
// in_ready and out_valid are decoded from the state register only, so
// there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous, active-high; drops all held entries
//   in_valid    in   1   upstream entry valid
//   in_ready    out  1   high while fewer than two entries are held
//   in_entry    in   W   entry to store
//   out_valid   out  1   head entry valid
//   out_ready   in   1   downstream accepts head entry
//   out_entry   out  W   head entry (holds its last value when empty)
// Only with WB_FORWARD_EN defined:
//   skid_valid  out  1   second (younger) entry is held
//   skid_entry  out  W   second (younger) entry
// -----------------------------------------------------------------------------
module wb_skid_buffer
    import wb_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_entry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_entry
`ifdef WB_FORWARD_EN
    ,
    output logic         skid_valid,
    output logic [W-1:0] skid_entry
`endif
);

    wb_state_t    state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         acc, ret;

    assign in_ready  = (state_q != WB_FULL);
    assign out_valid = (state_q != WB_EMPTY);
    assign out_entry = head_q;

`ifdef WB_FORWARD_EN
    assign skid_valid = (state_q == WB_FULL);
    assign skid_entry = skid_q;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        acc     = in_valid && in_ready;
        ret     = out_valid && out_ready;

        case (state_q)
            WB_EMPTY: begin
                if (acc) begin
                    head_d  = in_entry;
                    state_d = WB_ONE;
                end
            end
            WB_ONE: begin
                if (acc && ret) begin
                    // Head retires this edge; the new entry takes its place.
                    head_d = in_entry;
                end else if (acc) begin
                    skid_d  = in_entry;
                    state_d = WB_FULL;
                end else if (ret) begin
                    state_d = WB_EMPTY;
                end
            end
            WB_FULL: begin
                // in_ready is low here, so only a retire can happen.
                if (ret) begin
                    head_d  = skid_q;
                    state_d = WB_ONE;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    // NOTE: non-blocking assignments in the clocked block so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WB_EMPTY;
            // NOTE: the entry registers are reset too: the outputs are
            // defined as zero after reset, and the forward compare reads
            // the skid slot.
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/wb_select_pipe.sv
// -----------------------------------------------------------------------------
// wb_select_pipe
// Writeback select stage: picks one of NSRC source words at accept time and
// queues {data, rd, we} in a 2-entry skid buffer in front of the register
// file write port.
//   - in_sel >= NSRC stores data 0 and sets the sticky sel_err flag.
//   - in_rd == 0 forces the stored write enable low (x0 is never written);
//     the data is still passed through.
// Optional feature macro: WB_FORWARD_EN adds a combinational forward port
// (fwd_rd in, fwd_hit / fwd_data out) that looks up held entries by rd.
//
// Parameters
//   DATA_W  width of each source word and of out_data
//   NSRC    number of selectable sources (>= 2)
//   ADDR_W  destination register address width
// Ports
//   clk        in   1              rising-edge clock
//   reset      in   1              synchronous, active-high
//   in_valid   in   1              upstream entry valid
//   in_ready   out  1              registered; high iff fewer than 2 held
//   in_sel     in   sel_w(NSRC)    source index
//   in_src     in   NSRC*DATA_W    source k = in_src[k*DATA_W +: DATA_W]
//   in_rd      in   ADDR_W         destination register
//   in_we      in   1              register write request
//   out_valid  out  1              head entry valid
//   out_ready  in   1              register file accepts head entry
//   out_data   out  DATA_W         head entry data
//   out_rd     out  ADDR_W         head entry destination
//   out_we     out  1              head entry write enable
//   sel_err    out  1              sticky out-of-range select seen
//   fwd_rd     in   ADDR_W         (WB_FORWARD_EN) lookup register
//   fwd_hit    out  1              (WB_FORWARD_EN) a held entry writes fwd_rd
//   fwd_data   out  DATA_W         (WB_FORWARD_EN) data of youngest match
// -----------------------------------------------------------------------------
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NSRC   = 4,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [sel_w(NSRC)-1:0]   in_sel,
    input  logic [NSRC*DATA_W-1:0]   in_src,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic                     in_we,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_rd,
    output logic                     out_we,
    output logic                     sel_err
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0]        fwd_rd,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
`endif
);

    localparam int SEL_W   = sel_w(NSRC);
    localparam int ENTRY_W = DATA_W + ADDR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
        logic              we;
    } entry_t;

    entry_t in_entry;
    entry_t head;
    logic   sel_bad;
    logic   sel_err_q, sel_err_d;

    // N:1 select. An out-of-range index matches no source, leaving data 0.
    always_comb begin
        in_entry.data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                in_entry.data = in_src[k*DATA_W +: DATA_W];
            end
        end
        in_entry.rd = in_rd;
        in_entry.we = in_we && (in_rd != '0);
        sel_bad     = (int'(in_sel) >= NSRC);
    end

    always_comb begin
        sel_err_d = sel_err_q | (in_valid && in_ready && sel_bad);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

`ifdef WB_FORWARD_EN
    logic   skid_valid;
    entry_t skid;
`endif

    wb_skid_buffer #(
        .W (ENTRY_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_entry   (in_entry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_entry  (head)
`ifdef WB_FORWARD_EN
        ,
        .skid_valid (skid_valid),
        .skid_entry (skid)
`endif
    );

    assign out_data = head.data;
    assign out_rd   = head.rd;
    assign out_we   = head.we;

`ifdef WB_FORWARD_EN
    // The skid entry is younger than the head, so it is checked last and
    // overrides a head match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rd != '0) begin
            if (out_valid && head.we && (head.rd == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = head.data;
            end
            if (skid_valid && skid.we && (skid.rd == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = skid.data;
            end
        end
    end
`endif

endmodule
